// File: rtl/vga16_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga16_pkg                                                          |
// | Shared widths, host field selects and vector entry type.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vga16_pkg;

  localparam int AW = 10;
  localparam int XW = 10;
  localparam int CW = 16;

  localparam logic [1:0] FLD_P0  = 2'd0;
  localparam logic [1:0] FLD_P1  = 2'd1;
  localparam logic [1:0] FLD_COL = 2'd2;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [XW-1:0] y0;
    logic [XW-1:0] x1;
    logic [XW-1:0] y1;
    logic [CW-1:0] col;
  } vec_entry_t;

endpackage
`default_nettype wire

// File: rtl/vector_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vector_bank                                                        |
// | One vector-list RAM: per-field writes, enabled registered read.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vector_bank #(
  parameter int AW = vga16_pkg::AW,
  parameter int XW = vga16_pkg::XW,
  parameter int CW = vga16_pkg::CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [1:0]      wr_field,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*XW-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*XW-1:0] rd_p0,
  output logic [2*XW-1:0] rd_p1,
  output logic [CW-1:0]   rd_col
);
  import vga16_pkg::*;

  logic [2*XW-1:0] mem_p0  [0:(1<<AW)-1];
  logic [2*XW-1:0] mem_p1  [0:(1<<AW)-1];
  logic [CW-1:0]   mem_col [0:(1<<AW)-1];

  logic [2*XW-1:0] rd_p0_q, rd_p0_d;
  logic [2*XW-1:0] rd_p1_q, rd_p1_d;
  logic [CW-1:0]   rd_col_q, rd_col_d;

  // Field 3 matches none of the selects, so it is silently dropped.
  always_ff @(posedge clk) begin
    if (we && (wr_field == FLD_P0))  mem_p0[wr_addr]  <= wr_data;
    if (we && (wr_field == FLD_P1))  mem_p1[wr_addr]  <= wr_data;
    if (we && (wr_field == FLD_COL)) mem_col[wr_addr] <= wr_data[CW-1:0];
  end

  always_comb begin
    rd_p0_d  = rd_p0_q;
    rd_p1_d  = rd_p1_q;
    rd_col_d = rd_col_q;
    if (rd_en) begin
      rd_p0_d  = mem_p0[rd_addr];
      rd_p1_d  = mem_p1[rd_addr];
      rd_col_d = mem_col[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p0_q  <= '0;
      rd_p1_q  <= '0;
      rd_col_q <= '0;
    end else begin
      rd_p0_q  <= rd_p0_d;
      rd_p1_q  <= rd_p1_d;
      rd_col_q <= rd_col_d;
    end
  end

  assign rd_p0  = rd_p0_q;
  assign rd_p1  = rd_p1_q;
  assign rd_col = rd_col_q;

endmodule
`default_nettype wire

// File: rtl/vector_list_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vector_list_ctrl                                                   |
// | Double-buffered vector list; committed lists swap in at trigger.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vector_list_ctrl #(
  parameter int AW = vga16_pkg::AW,
  parameter int XW = vga16_pkg::XW,
  parameter int CW = vga16_pkg::CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trigger,
  input  logic [AW-1:0]   vector,
  input  logic            read_vector,
  output logic [XW-1:0]   x0,
  output logic [XW-1:0]   y0,
  output logic [XW-1:0]   x1,
  output logic [XW-1:0]   y1,
  output logic [CW-1:0]   col,
  output logic            last_vector,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [1:0]      wr_field,
  input  logic [2*XW-1:0] wr_data,
  input  logic            commit,
  input  logic [AW-1:0]   commit_count,
  input  logic            clr_err,
  output logic            pending,
  output logic            front_bank,
  output logic            swapped,
  output logic            overrun
);

  logic          front_bank_q, front_bank_d;
  logic [AW-1:0] front_count_q, front_count_d;
  logic [AW-1:0] back_count_q, back_count_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          swapped_q, swapped_d;
  logic          rd_sel_q, rd_sel_d;
  logic          last_q, last_d;

  logic            w_wr_ok;
  logic [1:0]      w_we;
  logic [2*XW-1:0] w_p0  [2];
  logic [2*XW-1:0] w_p1  [2];
  logic [CW-1:0]   w_col [2];

  // Writes always target the bank the drawer is not reading.
  assign w_wr_ok = wr_en && !pending_q;
  assign w_we[0] = w_wr_ok && front_bank_q;
  assign w_we[1] = w_wr_ok && !front_bank_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    vector_bank #(.AW(AW), .XW(XW), .CW(CW)) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (w_we[b]),
      .wr_field (wr_field),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (read_vector),
      .rd_addr  (vector),
      .rd_p0    (w_p0[b]),
      .rd_p1    (w_p1[b]),
      .rd_col   (w_col[b])
    );
  end

  always_comb begin
    front_bank_d  = front_bank_q;
    front_count_d = front_count_q;
    back_count_d  = back_count_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    swapped_d     = 1'b0;
    rd_sel_d      = rd_sel_q;
    last_d        = last_q;

    if (read_vector) begin
      rd_sel_d = front_bank_q;
      last_d   = (vector >= front_count_q);
    end

    // Swap keys off the registered pending, so a same-cycle commit waits a frame.
    if (trigger && pending_q) begin
      front_bank_d  = ~front_bank_q;
      front_count_d = back_count_q;
      pending_d     = 1'b0;
      swapped_d     = 1'b1;
    end

    if (commit && !pending_q) begin
      pending_d    = 1'b1;
      back_count_d = commit_count;
    end

    if (pending_q && (wr_en || commit)) overrun_d = 1'b1;
    if (clr_err) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_bank_q  <= 1'b0;
      front_count_q <= '0;
      back_count_q  <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      swapped_q     <= 1'b0;
      rd_sel_q      <= 1'b0;
      last_q        <= 1'b1;
    end else begin
      front_bank_q  <= front_bank_d;
      front_count_q <= front_count_d;
      back_count_q  <= back_count_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      swapped_q     <= swapped_d;
      rd_sel_q      <= rd_sel_d;
      last_q        <= last_d;
    end
  end

  // Sentinel reads present zeros regardless of stale RAM contents.
  always_comb begin
    x0  = '0;
    y0  = '0;
    x1  = '0;
    y1  = '0;
    col = '0;
    if (!last_q) begin
      x0  = w_p0[rd_sel_q][XW-1:0];
      y0  = w_p0[rd_sel_q][2*XW-1:XW];
      x1  = w_p1[rd_sel_q][XW-1:0];
      y1  = w_p1[rd_sel_q][2*XW-1:XW];
      col = w_col[rd_sel_q];
    end
  end

  assign last_vector = last_q;
  assign pending     = pending_q;
  assign front_bank  = front_bank_q;
  assign swapped     = swapped_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire
